// File: rtl/ped_tracker.sv
// ped_tracker: per-channel pedestal (baseline) tracker and subtractor.
// The tracker learns the baseline of raw unsigned ADC samples by averaging
// 2^PBITS quiet samples. It outputs signed, pedestal-subtracted 16-bit data
// two clocks after the sample.
// Optional feature macro: PED_FIXED_EN. It adds the fixped/usefixed ports,
// which force an externally supplied pedestal.
// Requires ABITS <= 15 so that the signed 16-bit difference cannot wrap.

module ped_tracker #(
    parameter int ABITS  = 12,
    parameter int PBITS  = 4,
    parameter int REJMAX = 1024
) (
    input  logic             ADCCLK,
    input  logic             reset,
    input  logic [ABITS-1:0] adc,
    input  logic [ABITS-1:0] pedwin,
    input  logic             freeze,
`ifdef PED_FIXED_EN
    input  logic [ABITS-1:0] fixped,
    input  logic             usefixed,
`endif
    output logic [15:0]      dout,
    output logic [ABITS-1:0] ped,
    output logic             pedvalid,
    output logic             pedupd
);

    localparam int ACCW  = ABITS + PBITS;
    localparam int RBITS = $clog2(REJMAX + 1);
    localparam int PAD   = 16 - ABITS;

    localparam logic [PBITS-1:0] CNT_LAST = {PBITS{1'b1}};
    localparam logic [PBITS-1:0] CNT_ONE  = PBITS'(1);
    localparam logic [RBITS-1:0] REJ_LAST = RBITS'(REJMAX - 1);
    localparam logic [RBITS-1:0] REJ_ONE  = RBITS'(1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Absolute value of a 16-bit two's complement difference.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        abs16 = v[15] ? (16'd0 - v) : v;
    endfunction

    // Input stage: sample, its valid flag and the freeze that travels with it.
    logic [ABITS-1:0] adc_q;
    logic             vld_q;
    logic             frz_q;

    // Tracker state.
    state_t           state_q,    state_d;
    logic [ACCW-1:0]  acc_q,      acc_d;
    logic [PBITS-1:0] cnt_q,      cnt_d;
    logic [RBITS-1:0] rej_q,      rej_d;

    // Registered outputs.
    logic [ABITS-1:0] ped_q,      ped_d;
    logic             pedvalid_q, pedvalid_d;
    logic             pedupd_q,   pedupd_d;
    logic [15:0]      dout_q,     dout_d;

    // Datapath helpers.
    logic [15:0]      diff_s;
    logic             in_win_s;
    logic             accept_s;
    logic [ACCW-1:0]  sum_s;
    logic             fix_s;
    logic [ABITS-1:0] fixped_s;

`ifdef PED_FIXED_EN
    assign fix_s    = usefixed;
    assign fixped_s = fixped;
`else
    assign fix_s    = 1'b0;
    assign fixped_s = {ABITS{1'b0}};
`endif

    // Signed difference, window test and running-sum candidate for the staged sample.
    always_comb begin
        diff_s   = {{PAD{1'b0}}, adc_q} - {{PAD{1'b0}}, ped_q};
        in_win_s = (abs16(diff_s) <= {{PAD{1'b0}}, pedwin});
        sum_s    = acc_q + {{PBITS{1'b0}}, adc_q};
        case (state_q)
            ST_INIT:  accept_s = 1'b1;
            ST_TRACK: accept_s = in_win_s;
            default:  accept_s = 1'b0;
        endcase
    end

    // Next-state logic: forced pedestal, freeze, accept/average and reject/relearn.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rej_d      = rej_q;
        ped_d      = ped_q;
        pedvalid_d = pedvalid_q;
        pedupd_d   = 1'b0;
        // The difference always uses the pedestal in force before this edge.
        dout_d     = pedvalid_q ? diff_s : 16'd0;

        if (fix_s) begin
            // The external pedestal wins. Learning is parked at INIT from scratch.
            ped_d      = fixped_s;
            pedvalid_d = 1'b1;
            state_d    = ST_INIT;
            acc_d      = {ACCW{1'b0}};
            cnt_d      = {PBITS{1'b0}};
            rej_d      = {RBITS{1'b0}};
        end else if (!vld_q || frz_q) begin
            // No sample to judge, or a frozen sample: the tracker holds.
            state_d = state_q;
        end else if (accept_s) begin
            rej_d = {RBITS{1'b0}};
            if (cnt_q == CNT_LAST) begin
                ped_d      = sum_s[ACCW-1:PBITS];
                acc_d      = {ACCW{1'b0}};
                cnt_d      = {PBITS{1'b0}};
                pedupd_d   = 1'b1;
                pedvalid_d = 1'b1;
                state_d    = ST_TRACK;
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            if (rej_q == REJ_LAST) begin
                // The baseline has moved for good. Relearn, but keep the old pedestal meanwhile.
                state_d = ST_INIT;
                acc_d   = {ACCW{1'b0}};
                cnt_d   = {PBITS{1'b0}};
                rej_d   = {RBITS{1'b0}};
            end else begin
                rej_d = rej_q + REJ_ONE;
            end
        end
    end

    // Single state register: input stage, tracker state and registered outputs.
    always_ff @(posedge ADCCLK) begin
        if (reset) begin
            adc_q      <= {ABITS{1'b0}};
            vld_q      <= 1'b0;
            frz_q      <= 1'b0;
            state_q    <= ST_INIT;
            acc_q      <= {ACCW{1'b0}};
            cnt_q      <= {PBITS{1'b0}};
            rej_q      <= {RBITS{1'b0}};
            ped_q      <= {ABITS{1'b0}};
            pedvalid_q <= 1'b0;
            pedupd_q   <= 1'b0;
            dout_q     <= 16'd0;
        end else begin
            adc_q      <= adc;
            vld_q      <= 1'b1;
            frz_q      <= freeze;
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rej_q      <= rej_d;
            ped_q      <= ped_d;
            pedvalid_q <= pedvalid_d;
            pedupd_q   <= pedupd_d;
            dout_q     <= dout_d;
        end
    end

    assign dout     = dout_q;
    assign ped      = ped_q;
    assign pedvalid = pedvalid_q;
    assign pedupd   = pedupd_q;

endmodule
